uart_sol_trx: RTL and testbench

// - Fixed-format 8N1 UART transceiver: one receiver (rx) and one transmitter (tx) sharing one clock and reset.
// - Sits between the board RX/TX pins and the host-command FSM.
//   - RX side delivers each received byte with a 1-cycle valid strobe.
//   - TX side accepts a byte with an en/rdy handshake.
// - Bit timing is derived from parameters; there is no runtime baud configuration.

---
 rtl/uart_sol_trx.sv | 164 ++++++++++++++++
 tb/tb_uart_sol_trx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sol_trx.sv
// rtl/uart_sol_trx.sv - fixed-format 8N1 UART transceiver with independent RX and TX paths
module uart_sol_trx #(
    parameter int FREQ      = 32000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_din,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       tx_en,
    input  logic [7:0] tx_data,
    output logic       tx_rdy,
    output logic       tx_dout
);

    localparam int CLKS_PER_BIT = FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    // ---------------- transmitter ----------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t        tx_state, tx_state_nxt;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_idx;
    logic [7:0]       tx_shift;
    logic             tx_bit_done;

    assign tx_bit_done = (tx_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tx_state <= TX_IDLE;
        else      tx_state <= tx_state_nxt;
    end

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            TX_IDLE:  if (tx_en) tx_state_nxt = TX_START;
            TX_START: if (tx_bit_done) tx_state_nxt = TX_DATA;
            TX_DATA:  if (tx_bit_done && tx_idx == 3'd7) tx_state_nxt = TX_STOP;
            TX_STOP:  if (tx_bit_done) tx_state_nxt = TX_IDLE;
            default:  tx_state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_rdy  = (tx_state == TX_IDLE);
        tx_dout = 1'b1;
        case (tx_state)
            TX_START: tx_dout = 1'b0;
            TX_DATA:  tx_dout = tx_shift[0];
            default:  tx_dout = 1'b1;
        endcase
    end

    // The byte is captured only on acceptance, so later tx_data changes cannot leak in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_cnt   <= '0;
            tx_idx   <= 3'd0;
            tx_shift <= 8'h00;
        end else if (tx_state == TX_IDLE) begin
            tx_cnt <= '0;
            tx_idx <= 3'd0;
            if (tx_en) tx_shift <= tx_data;
        end else if (tx_bit_done) begin
            tx_cnt <= '0;
            if (tx_state == TX_DATA) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_idx   <= tx_idx + 3'd1;
            end
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

    // ---------------- receiver ----------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_ERR} rx_state_t;

    rx_state_t        rx_state, rx_state_nxt;
    logic             rx_sync1, rx_sync2, rx_prev;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_idx;
    logic [7:0]       rx_shift;
    logic             rx_bit_done, rx_half_done, rx_fall;

    assign rx_bit_done  = (rx_cnt == BIT_LAST);
    assign rx_half_done = (rx_cnt == HALF_LAST);
    assign rx_fall      = rx_prev & ~rx_sync2;

    // Synchronizer flops reset high so the idle line never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_prev  <= 1'b1;
        end else begin
            rx_sync1 <= rx_din;
            rx_sync2 <= rx_sync1;
            rx_prev  <= rx_sync2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_state <= RX_IDLE;
        else      rx_state <= rx_state_nxt;
    end

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_state_nxt = RX_START;
            RX_START: if (rx_half_done) rx_state_nxt = rx_sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_bit_done && rx_idx == 3'd7) rx_state_nxt = RX_STOP;
            RX_STOP:  if (rx_bit_done) rx_state_nxt = rx_sync2 ? RX_IDLE : RX_ERR;
            RX_ERR:   if (rx_sync2) rx_state_nxt = RX_IDLE;
            default:  rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_cnt   <= '0;
            rx_idx   <= 3'd0;
            rx_shift <= 8'h00;
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
        end else begin
            rx_valid <= 1'b0;
            case (rx_state)
                RX_START: rx_cnt <= rx_half_done ? '0 : rx_cnt + 1'b1;
                RX_DATA: begin
                    if (rx_bit_done) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync2, rx_shift[7:1]};
                        rx_idx   <= rx_idx + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_bit_done) begin
                        rx_cnt <= '0;
                        if (rx_sync2) begin
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    rx_cnt <= '0;
                    rx_idx <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_sol_trx.sv
// tb/tb_uart_sol_trx.sv - directed self-checking bench for uart_sol_trx at 16 clocks per bit
module tb_uart_sol_trx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_drv = 1'b1;
    logic       loop = 1'b0;
    logic       rx_din;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_en = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_rdy;
    logic       tx_dout;

    assign rx_din = loop ? tx_dout : rx_drv;

    always #5 clk = ~clk;

    uart_sol_trx #(.FREQ(160), .BAUD_RATE(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_din   (rx_din),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_en    (tx_en),
        .tx_data  (tx_data),
        .tx_rdy   (tx_rdy),
        .tx_dout  (tx_dout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // rx_valid monitor: pulse count, time of last pulse, back-to-back pulses
    int   cyc = 0;
    int   valid_cnt = 0;
    int   consec = 0;
    int   last_valid_cyc = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            if (prev_v) consec++;
        end
        prev_v = rx_valid;
    end

    task automatic wait_rdy();
        int k = 0;
        while (tx_rdy !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (tx_rdy !== 1'b1) check("tx_rdy_timeout", 32'd0, 32'd1);
    endtask

    // Sends one byte and checks the line level every cycle against the expected 10-bit frame.
    task automatic tx_frame(input logic [7:0] b, input logic [9:0] line, input bit inject,
                            output int acc_cyc);
        int err[10];
        int rdy_err = 0;
        acc_cyc = 0;
        for (int k = 0; k < 10; k++) err[k] = 0;
        wait_rdy();
        tx_en   = 1'b1;
        tx_data = b;
        @(posedge clk);
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            if (i == 0) begin
                acc_cyc = cyc;
                tx_en   = 1'b0;
                tx_data = ~b;
            end
            if (inject && i == 40) begin
                tx_en   = 1'b1;
                tx_data = 8'hAA;
            end
            if (inject && i == 41) tx_en = 1'b0;
            if (tx_dout !== line[i/16]) err[i/16]++;
            if (tx_rdy !== 1'b0) rdy_err++;
        end
        for (int k = 0; k < 10; k++)
            check($sformatf("tx_%02h_bit%0d_errs", b, k), err[k], 32'd0);
        check($sformatf("tx_%02h_rdy_low_160", b), rdy_err, 32'd0);
        @(negedge clk);
        check($sformatf("tx_%02h_rdy_after", b), {31'd0, tx_rdy}, 32'd1);
        check($sformatf("tx_%02h_idle_line", b), {31'd0, tx_dout}, 32'd1);
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
        rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx_drv = b[k];
            repeat (16) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (16) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
    } tx_vec_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_pulses;
        logic [7:0] exp_data;
    } rx_vec_t;

    tx_vec_t tx_tab[4];
    rx_vec_t rx_tab[5];

    initial begin
        int acc;
        int v0;
        int lat;
        int idle_err;

        tx_tab[0] = '{8'h55, 10'h2AA};
        tx_tab[1] = '{8'h00, 10'h200};
        tx_tab[2] = '{8'hFF, 10'h3FE};
        tx_tab[3] = '{8'h81, 10'h302};

        rx_tab[0] = '{8'h41, 1'b0, 0, 8'h67};
        rx_tab[1] = '{8'h1B, 1'b1, 1, 8'h1B};
        rx_tab[2] = '{8'hC3, 1'b1, 1, 8'hC3};
        rx_tab[3] = '{8'h80, 1'b0, 0, 8'hC3};
        rx_tab[4] = '{8'h5A, 1'b1, 1, 8'h5A};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_tx_dout", {31'd0, tx_dout}, 32'd1);
        check("rst_tx_rdy", {31'd0, tx_rdy}, 32'd1);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // transmitter frames
        for (int t = 0; t < 4; t++)
            tx_frame(tx_tab[t].data, tx_tab[t].line, 1'b0, acc);

        // send request mid-frame must be dropped
        tx_frame(8'h55, 10'h2AA, 1'b1, acc);
        idle_err = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_dout !== 1'b1 || tx_rdy !== 1'b1) idle_err++;
        end
        check("tx_aa_not_sent", idle_err, 32'd0);

        // loopback "g"
        loop = 1'b1;
        v0 = valid_cnt;
        tx_frame(8'h67, 10'h2CE, 1'b0, acc);
        repeat (30) @(negedge clk);
        check("loop_67_pulses", valid_cnt - v0, 32'd1);
        check("loop_67_data", {24'd0, rx_data}, 32'h67);
        lat = last_valid_cyc - acc;
        check("loop_67_latency_150_160", {31'd0, (lat >= 150 && lat <= 160)}, 32'd1);
        loop = 1'b0;
        repeat (10) @(negedge clk);

        // externally driven frames, including framing errors
        for (int t = 0; t < 5; t++) begin
            v0 = valid_cnt;
            drive_rx(rx_tab[t].data, rx_tab[t].stop_bit);
            check($sformatf("rx_%02h_pulses", rx_tab[t].data), valid_cnt - v0, rx_tab[t].exp_pulses);
            check($sformatf("rx_%02h_data", rx_tab[t].data), {24'd0, rx_data}, {24'd0, rx_tab[t].exp_data});
        end

        // short low glitch, then a real frame
        v0 = valid_cnt;
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_no_pulse", valid_cnt - v0, 32'd0);
        check("glitch_data_kept", {24'd0, rx_data}, 32'h5A);
        v0 = valid_cnt;
        drive_rx(8'h74, 1'b1);
        check("after_glitch_pulses", valid_cnt - v0, 32'd1);
        check("after_glitch_data", {24'd0, rx_data}, 32'h74);

        // asynchronous reset in the middle of a loopback frame
        loop = 1'b1;
        wait_rdy();
        tx_en   = 1'b1;
        tx_data = 8'hC5;
        @(negedge clk);
        tx_en = 1'b0;
        repeat (70) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_tx_dout", {31'd0, tx_dout}, 32'd1);
        check("midrst_tx_rdy", {31'd0, tx_rdy}, 32'd1);
        check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        v0 = valid_cnt;
        tx_frame(8'h00, 10'h200, 1'b0, acc);
        repeat (30) @(negedge clk);
        check("post_rst_00_pulses", valid_cnt - v0, 32'd1);
        check("post_rst_00_data", {24'd0, rx_data}, 32'h00);
        v0 = valid_cnt;
        tx_frame(8'hFF, 10'h3FE, 1'b0, acc);
        repeat (30) @(negedge clk);
        check("post_rst_ff_pulses", valid_cnt - v0, 32'd1);
        check("post_rst_ff_data", {24'd0, rx_data}, 32'hFF);

        check("rx_valid_never_back_to_back", consec, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
